// File: rtl/accel_seq_pkg.sv
// accel_seq_pkg: shared state encodings, register map and command bits for the accelerometer sequencer
package accel_seq_pkg;
    localparam logic [2:0] S_WHOAMI = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_IDLE   = 3'd2;
    localparam logic [2:0] S_RD     = 3'd3;
    localparam logic [2:0] S_PUB    = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_REQ  = 2'd1;
    localparam logic [1:0] T_WAIT = 2'd2;
    localparam logic [7:0] REG_WHO_AM_I = 8'h0F;
    localparam logic [7:0] REG_CTRL1    = 8'h20;
    localparam logic [7:0] REG_TEMP_CFG = 8'h1F;
    localparam logic [7:0] REG_CTRL4    = 8'h23;
    localparam logic [7:0] REG_OUT_X_L  = 8'h28;
    localparam logic [7:0] CMD_RD       = 8'h80;
    localparam logic [7:0] CMD_AUTO_INC = 8'h40;
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_WHOAMI  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
endpackage

// File: rtl/accel_seq_multi_txn.sv
// spi_txn_ctrl: one spi_request/spi_ready handshake with a timeout on each phase
module spi_txn_ctrl
    import accel_seq_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic        clk_in,
    input  logic        nrst,
    input  logic        start,
    input  logic [31:0] frame,
    input  logic [4:0]  nbits,
    input  logic        spi_ready,
    input  logic [31:0] spi_miso_data,
    output logic [31:0] spi_mosi_data,
    output logic [4:0]  spi_nbits,
    output logic        spi_request,
    output logic        busy,
    output logic        done,
    output logic [31:0] rx,
    output logic        timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [1:0]    st;
    logic [CW-1:0] cnt;
    logic          expired;
    assign busy    = st != T_IDLE;
    assign expired = cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            st            <= T_IDLE;
            cnt           <= '0;
            spi_mosi_data <= '0;
            spi_nbits     <= '0;
            spi_request   <= 1'b0;
            done          <= 1'b0;
            rx            <= '0;
            timeout       <= 1'b0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            cnt     <= cnt + 1'b1;
            case (st)
                T_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        st            <= T_REQ;
                        spi_request   <= 1'b1;
                        spi_mosi_data <= frame;
                        spi_nbits     <= nbits;
                    end
                end
                T_REQ: begin
                    // ready already low here also counts as acceptance
                    if (!spi_ready) begin
                        st          <= T_WAIT;
                        spi_request <= 1'b0;
                        cnt         <= '0;
                    end else if (expired) begin
                        st          <= T_IDLE;
                        spi_request <= 1'b0;
                        timeout     <= 1'b1;
                    end
                end
                T_WAIT: begin
                    if (spi_ready) begin
                        st   <= T_IDLE;
                        rx   <= spi_miso_data;
                        done <= 1'b1;
                    end else if (expired) begin
                        st      <= T_IDLE;
                        timeout <= 1'b1;
                    end
                end
                default: st <= T_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/accel_seq_multi.sv
// accel_seq_multi: WHO_AM_I check, register init and multi-axis sample polling over the SPI master
module accel_seq_multi
    import accel_seq_pkg::*;
#(
    parameter int         NUM_AXES    = 3,
    parameter logic [7:0] WHOAMI_VAL  = 8'h33,
    parameter int         MAX_RETRY   = 3,
    parameter logic [7:0] CTRL1_VAL   = 8'h77,
    parameter logic [7:0] TEMPCFG_VAL = 8'hC0,
    parameter logic [7:0] CTRL4_VAL   = 8'h88,
    parameter int         GAP_CYCLES  = 16,
    parameter int         TIMEOUT     = 4096
) (
    input  logic                    clk_in,
    input  logic                    nrst,
    input  logic                    enable,
    output logic [31:0]             spi_mosi_data,
    input  logic [31:0]             spi_miso_data,
    output logic [4:0]              spi_nbits,
    output logic                    spi_request,
    input  logic                    spi_ready,
    output logic [16*NUM_AXES-1:0]  sample_data,
    output logic                    sample_valid,
    output logic [15:0]             sample_count,
    output logic                    init_done,
    output logic                    err,
    output logic [1:0]              err_code
);
    logic [2:0]             state;
    logic [1:0]             init_idx;
    logic [1:0]             axis;
    logic [7:0]             retry_cnt;
    logic [15:0]            gap_cnt;
    logic [16*NUM_AXES-1:0] shadow;
    logic [31:0]            frame;
    logic [31:0]            rx;
    logic [4:0]             nbits;
    logic [15:0]            init_word;
    logic [7:0]             rd_addr;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   timeout;
    logic                   unused_rx;
    assign unused_rx = ^rx[31:16];
    assign init_word = init_idx == 2'd0 ? {REG_CTRL1, CTRL1_VAL}
                     : init_idx == 2'd1 ? {REG_TEMP_CFG, TEMPCFG_VAL}
                     : {REG_CTRL4, CTRL4_VAL};
    assign rd_addr = REG_OUT_X_L + {5'd0, axis, 1'b0};
    assign frame = state == S_RD   ? {8'h00, CMD_RD | CMD_AUTO_INC | rd_addr, 16'h0000}
                 : state == S_INIT ? {16'h0000, init_word}
                 : {16'h0000, CMD_RD | REG_WHO_AM_I, 8'h00};
    assign nbits = state == S_RD ? 5'd23 : 5'd15;
    // a new frame starts the cycle after the previous one reports back
    assign start = (state == S_WHOAMI || state == S_INIT || state == S_RD) && !busy && !done && !timeout;
    spi_txn_ctrl #(.TIMEOUT(TIMEOUT)) u_txn (
        .clk_in        (clk_in),
        .nrst          (nrst),
        .start         (start),
        .frame         (frame),
        .nbits         (nbits),
        .spi_ready     (spi_ready),
        .spi_miso_data (spi_miso_data),
        .spi_mosi_data (spi_mosi_data),
        .spi_nbits     (spi_nbits),
        .spi_request   (spi_request),
        .busy          (busy),
        .done          (done),
        .rx            (rx),
        .timeout       (timeout)
    );
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            state        <= S_WHOAMI;
            init_idx     <= '0;
            axis         <= '0;
            retry_cnt    <= '0;
            gap_cnt      <= '0;
            shadow       <= '0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            sample_count <= '0;
            init_done    <= 1'b0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
        end else begin
            sample_valid <= state == S_PUB;
            sample_count <= sample_count + 16'(state == S_PUB);
            if (timeout) begin
                state    <= S_HALT;
                err      <= 1'b1;
                err_code <= ERR_TIMEOUT;
            end else begin
                case (state)
                    S_WHOAMI: if (done) begin
                        if (rx[7:0] == WHOAMI_VAL) begin
                            state    <= S_INIT;
                            init_idx <= '0;
                        end else if (retry_cnt == 8'(MAX_RETRY - 1)) begin
                            state    <= S_HALT;
                            err      <= 1'b1;
                            err_code <= ERR_WHOAMI;
                        end else begin
                            retry_cnt <= retry_cnt + 1'b1;
                        end
                    end
                    S_INIT: if (done) begin
                        init_idx <= init_idx + 1'b1;
                        if (init_idx == 2'd2) begin
                            init_done <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                    S_IDLE: if (enable) begin
                        state <= S_RD;
                        axis  <= '0;
                    end
                    S_RD: if (done) begin
                        // sensor returns L then H; store as H:L
                        for (int i = 0; i < NUM_AXES; i++)
                            if (axis == 2'(i)) shadow[16*i +: 16] <= {rx[7:0], rx[15:8]};
                        axis  <= axis + 1'b1;
                        state <= axis == 2'(NUM_AXES - 1) ? S_PUB : S_RD;
                    end
                    S_PUB: begin
                        sample_data <= shadow;
                        gap_cnt     <= '0;
                        state       <= GAP_CYCLES == 0 ? S_IDLE : S_GAP;
                    end
                    S_GAP: begin
                        gap_cnt <= gap_cnt + 1'b1;
                        if (gap_cnt == 16'(GAP_CYCLES - 1)) state <= S_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
